// File: rtl/timer_arbiter.sv
// Shared down-counter timebase with a round-robin arbiter in front of it.
// Each requester asks for a delay of req_count cycles and receives a one-cycle
// done pulse when that delay has run.
// Optional feature: define TIMER_ARB_TOGGLE_OUT_EN to add a per-requester toggle
// output that inverts on every done pulse.
module timer_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_count,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy
`ifdef TIMER_ARB_TOGGLE_OUT_EN
  ,
  output logic [NUM_REQ-1:0]             toggle
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {StIdle, StRun} state_t;

  state_t                 state_q, state_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     grant_d, done_d;
  logic                   busy_d;

  logic                   found;
  logic [IdxW-1:0]        winner;
  logic [IdxW-1:0]        cand;
  logic [IdxW-1:0]        owner_inc;

  // Round-robin search: first active request starting at the pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Pointer value after the current owner releases the counter.
  always_comb begin
    owner_inc = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant;
    done_d  = '0;
    busy_d  = busy;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StRun;
          owner_d = winner;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
          cnt_d   = req_count[winner*COUNT_WIDTH +: COUNT_WIDTH];
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (!req[owner_q]) begin
          // Owner dropped its request: release without a done pulse.
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = owner_inc;
        end else if (cnt_q == '0) begin
          state_d         = StIdle;
          done_d[owner_q] = 1'b1;
          grant_d         = '0;
          busy_d          = 1'b0;
          ptr_d           = owner_inc;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

`ifdef TIMER_ARB_TOGGLE_OUT_EN
  // Square-wave outputs: flip together with each done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle <= '0;
    end else begin
      toggle <= toggle ^ done_d;
    end
  end
`endif

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus pushes expected grant/done events
// with their edge numbers; a monitor pops and compares whenever one appears.
module tb_timer_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  req_count;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic              busy;
`ifdef TIMER_ARB_TOGGLE_OUT_EN
  logic [NR-1:0]     toggle;
`endif

  timer_arbiter #(
    .NUM_REQ     (NR),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .busy      (busy)
`ifdef TIMER_ARB_TOGGLE_OUT_EN
    ,
    .toggle    (toggle)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter: value k seen at a negedge means the last posedge was edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_done;
    logic [NR-1:0] val;
    int            at;
  } ev_t;

  ev_t           exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [NR-1:0] exp_tog = '0;

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input bit d, input logic [NR-1:0] v, input int at);
    ev_t e;
    e.is_done = d;
    e.val     = v;
    e.at      = at;
    exp_q.push_back(e);
  endtask

  task automatic observe(input bit d, input logic [NR-1:0] v);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got %b at edge %0d, expected nothing",
               d ? "done" : "grant", v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != d || e.val !== v || e.at != cyc) begin
        n_bad++;
        $display("FAIL event: got %s=%b at edge %0d, expected %s=%b at edge %0d",
                 d ? "done" : "grant", v, cyc, e.is_done ? "done" : "grant", e.val, e.at);
      end
    end
`ifdef TIMER_ARB_TOGGLE_OUT_EN
    if (d) begin
      exp_tog = exp_tog ^ v;
      check("toggle", 32'(toggle), 32'(exp_tog));
    end
`endif
  endtask

  // Monitor: report every rising grant and every done pulse to the scoreboard.
  initial begin
    logic [NR-1:0] prev_grant;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      if (grant !== '0 && grant !== prev_grant) observe(1'b0, grant);
      if (done !== '0) observe(1'b1, done);
      prev_grant = grant;
    end
  end

  task automatic set_count(input int i, input int n);
    req_count[i*CW +: CW] = CW'(n);
  endtask

  // Lone request from idx with count n; drops req on the done cycle.
  task automatic run_one(input int idx, input int n);
    int c;
    @(negedge clk);
    set_count(idx, n);
    req[idx] = 1'b1;
    c = cyc;
    expect_ev(1'b0, onehot(idx), c + 1);
    expect_ev(1'b1, onehot(idx), c + n + 2);
    @(negedge clk);
    check("busy_in_run", 32'(busy), 32'd1);
    while (cyc < c + n + 2) @(negedge clk);
    req[idx] = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    int t;
    int seq[5];
    int cnt[4];
    rst       = 1'b1;
    req       = '0;
    req_count = '0;
    repeat (2) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Idle: any grant/done here is flagged by the monitor.
    repeat (20) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_grant", 32'(grant), 32'd0);

    // Round-robin, all requests high, counts 3,1,2,0.
    seq = '{0, 1, 2, 3, 0};
    cnt = '{3, 1, 2, 0};
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_count(i, cnt[i]);
    req = '1;
    c = cyc;
    t = c + 1;
    for (int i = 0; i < 5; i++) begin
      expect_ev(1'b0, onehot(seq[i]), t);
      expect_ev(1'b1, onehot(seq[i]), t + cnt[seq[i]] + 1);
      t = t + cnt[seq[i]] + 2;
    end
    while (cyc < t - 1) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Single delay and zero count.
    run_one(2, 5);
    run_one(0, 0);

    // Abandon: req[1] count 100 dropped after 10 cycles while req[3] waits.
    @(negedge clk);
    set_count(1, 100);
    set_count(3, 2);
    req = 4'b0010;
    c = cyc;
    expect_ev(1'b0, 4'b0010, c + 1);
    repeat (10) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    check("abandon_grant", 32'(grant), 32'd0);
    check("abandon_busy", 32'(busy), 32'd0);
    expect_ev(1'b0, 4'b1000, c + 12);
    expect_ev(1'b1, 4'b1000, c + 15);
    while (cyc < c + 15) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);

    // Move the pointer to 3, then reset asynchronously mid-run.
    run_one(2, 0);
    @(negedge clk);
    set_count(1, 50);
    req = 4'b0010;
    c = cyc;
    expect_ev(1'b0, 4'b0010, c + 1);
    repeat (5) @(negedge clk);
    #2;
    rst     = 1'b1;
    exp_tog = '0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
`ifdef TIMER_ARB_TOGGLE_OUT_EN
    check("async_toggle", 32'(toggle), 32'd0);
`endif
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    // Pointer back at 0: req 0 and 3 together grant 0 first, then 3.
    @(negedge clk);
    set_count(0, 1);
    set_count(3, 2);
    req = 4'b1001;
    c = cyc;
    expect_ev(1'b0, 4'b0001, c + 1);
    expect_ev(1'b1, 4'b0001, c + 3);
    while (cyc < c + 3) @(negedge clk);
    req = 4'b1000;
    expect_ev(1'b0, 4'b1000, c + 4);
    expect_ev(1'b1, 4'b1000, c + 7);
    while (cyc < c + 7) @(negedge clk);
    req = '0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
